// File: rtl/store_queue.sv
// In-order store queue between the load/store issue stage and data memory.
// Stores wait for retirement, then drain through a valid/ready port.
module store_queue #(
  parameter int SQ_DEPTH     = 4,
  parameter int LOG2_MAX_IDS = 3,
  parameter int ID_W         = LOG2_MAX_IDS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_valid,
  output logic            push_ready,
  input  logic [31:0]     push_addr,
  input  logic [3:0]      push_be,
  input  logic [2:0]      push_fn3,
  input  logic [31:0]     push_data,
  input  logic [ID_W-1:0] push_id,
  input  logic            release_valid,
  input  logic [ID_W-1:0] release_id,
  input  logic            sq_flush,
  input  logic            load_check_valid,
  input  logic [31:0]     load_check_addr,
  output logic            load_conflict,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_addr,
  output logic [3:0]      out_be,
  output logic [2:0]      out_fn3,
  output logic [31:0]     out_data,
  output logic            sq_empty,
  output logic            no_released_stores_pending
);

  localparam int IDX_W = $clog2(SQ_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] head_ptr, rel_ptr, tail_ptr;
  logic [PTR_W-1:0] rel_next;
  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] head_idx, rel_idx, tail_idx;

  logic [31:0]     addr_mem [SQ_DEPTH];
  logic [3:0]      be_mem   [SQ_DEPTH];
  logic [2:0]      fn3_mem  [SQ_DEPTH];
  logic [31:0]     data_mem [SQ_DEPTH];
  logic [ID_W-1:0] id_mem   [SQ_DEPTH];

  logic do_push, do_release, do_pop;
  logic hit;
  logic [IDX_W-1:0] off;
  logic unused_load_bits;

  assign head_idx = head_ptr[IDX_W-1:0];
  assign rel_idx  = rel_ptr[IDX_W-1:0];
  assign tail_idx = tail_ptr[IDX_W-1:0];

  assign count      = tail_ptr - head_ptr;
  assign push_ready = (count != PTR_W'(SQ_DEPTH));
  assign out_valid  = (head_ptr != rel_ptr);
  assign sq_empty   = (head_ptr == tail_ptr);
  assign no_released_stores_pending = (head_ptr == rel_ptr);

  assign do_push    = push_valid && push_ready && !sq_flush;
  assign do_release = release_valid && (rel_ptr != tail_ptr);
  assign do_pop     = out_valid && out_ready;
  assign rel_next   = do_release ? rel_ptr + PTR_W'(1) : rel_ptr;

  assign out_addr = addr_mem[head_idx];
  assign out_be   = be_mem[head_idx];
  assign out_fn3  = fn3_mem[head_idx];
  assign out_data = data_mem[head_idx];

  assign unused_load_bits = ^load_check_addr[1:0];

  // A flush rewinds tail onto rel (after this cycle's release), so only retired stores survive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      rel_ptr  <= '0;
      tail_ptr <= '0;
    end else begin
      if (do_pop)
        head_ptr <= head_ptr + PTR_W'(1);
      rel_ptr <= rel_next;
      if (sq_flush)
        tail_ptr <= rel_next;
      else if (do_push)
        tail_ptr <= tail_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[tail_idx] <= push_addr;
      be_mem[tail_idx]   <= push_be;
      fn3_mem[tail_idx]  <= push_fn3;
      data_mem[tail_idx] <= push_data;
      id_mem[tail_idx]   <= push_id;
    end
  end

  // Slot i is occupied when its distance from head is below the occupancy count.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      off = IDX_W'(i) - head_idx;
      if (({1'b0, off} < count) && (addr_mem[i][31:2] == load_check_addr[31:2]))
        hit = 1'b1;
    end
  end

  assign load_conflict = load_check_valid && hit;

  release_id_matches: assert property (
    @(posedge clk) disable iff (rst)
    (release_valid && (rel_ptr != tail_ptr)) |-> (release_id == id_mem[rel_idx])
  );

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the store queue.
module tb_store_queue;

  localparam int DEPTH = 4;
  localparam int LOG2_MAX_IDS = 3;
  localparam int ID_W = LOG2_MAX_IDS;

  logic            clk = 1'b0;
  logic            rst;
  logic            push_valid, push_ready;
  logic [31:0]     push_addr;
  logic [3:0]      push_be;
  logic [2:0]      push_fn3;
  logic [31:0]     push_data;
  logic [ID_W-1:0] push_id;
  logic            release_valid;
  logic [ID_W-1:0] release_id;
  logic            sq_flush;
  logic            load_check_valid;
  logic [31:0]     load_check_addr;
  logic            load_conflict;
  logic            out_valid, out_ready;
  logic [31:0]     out_addr, out_data;
  logic [3:0]      out_be;
  logic [2:0]      out_fn3;
  logic            sq_empty, no_released_stores_pending;

  store_queue #(.SQ_DEPTH(DEPTH), .LOG2_MAX_IDS(LOG2_MAX_IDS), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
    .push_be(push_be), .push_fn3(push_fn3), .push_data(push_data), .push_id(push_id),
    .release_valid(release_valid), .release_id(release_id), .sq_flush(sq_flush),
    .load_check_valid(load_check_valid), .load_check_addr(load_check_addr),
    .load_conflict(load_conflict),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_be(out_be),
    .out_fn3(out_fn3), .out_data(out_data),
    .sq_empty(sq_empty), .no_released_stores_pending(no_released_stores_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     addr;
    logic [3:0]      be;
    logic [2:0]      fn3;
    logic [31:0]     data;
    logic [ID_W-1:0] id;
  } entry_t;

  // Model: queue of held stores, oldest first; the first mrel of them are released.
  entry_t mq[$];
  int     mrel;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ID_W-1:0] relId();
    if (mrel < mq.size()) return mq[mrel].id;
    return '0;
  endfunction

  task automatic checkOutput();
    logic exp_conf;
    exp_conf = 1'b0;
    foreach (mq[i])
      if (mq[i].addr[31:2] == load_check_addr[31:2]) exp_conf = 1'b1;
    chk("push_ready", push_ready, mq.size() != DEPTH);
    chk("out_valid", out_valid, mrel > 0);
    chk("sq_empty", sq_empty, mq.size() == 0);
    chk("no_rel_pending", no_released_stores_pending, mrel == 0);
    chk("load_conflict", load_conflict, load_check_valid && exp_conf);
    if (mrel > 0) begin
      chk("out_addr", out_addr, mq[0].addr);
      chk("out_be", out_be, mq[0].be);
      chk("out_fn3", out_fn3, mq[0].fn3);
      chk("out_data", out_data, mq[0].data);
    end
  endtask

  task automatic updateModel();
    int s;
    bit do_pop, do_rel, do_push;
    entry_t e;
    s       = mq.size();
    do_pop  = (mrel > 0) && out_ready;
    do_rel  = release_valid && (mrel < s);
    do_push = push_valid && (s != DEPTH) && !sq_flush;
    e.addr = push_addr; e.be = push_be; e.fn3 = push_fn3; e.data = push_data; e.id = push_id;
    if (do_pop) begin
      void'(mq.pop_front());
      mrel--;
    end
    if (do_rel) mrel++;
    if (sq_flush) begin
      while (mq.size() > mrel) void'(mq.pop_back());
    end else if (do_push) begin
      mq.push_back(e);
    end
  endtask

  // One clock: compare outputs for the inputs already applied, then advance the model.
  task automatic tick();
    #1;
    checkOutput();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mrel = 0;
    end else begin
      updateModel();
    end
    @(negedge clk);
  endtask

  task automatic idle();
    push_valid = 0; push_addr = '0; push_be = '0; push_fn3 = '0; push_data = '0; push_id = '0;
    release_valid = 0; release_id = '0; sq_flush = 0;
    load_check_valid = 0; load_check_addr = '0; out_ready = 0;
  endtask

  task automatic setPush(input logic [31:0] addr, input int id);
    push_valid = 1;
    push_addr  = addr;
    push_be    = 4'hF;
    push_fn3   = 3'b010;
    push_data  = $urandom;
    push_id    = ID_W'(id);
  endtask

  task automatic doReset();
    idle();
    rst = 1;
    mq.delete();
    mrel = 0;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic applyStimulus();
    idle();
    if ($urandom_range(0, 99) < 60)
      setPush(32'h100 + (32'($urandom_range(0, 15)) << 2), $urandom_range(0, 7));
    release_valid = ($urandom_range(0, 99) < 50);
    release_id    = (mrel < mq.size()) ? relId() : ID_W'($urandom);
    out_ready     = ($urandom_range(0, 99) < 55);
    sq_flush      = ($urandom_range(0, 99) < 5);
    load_check_valid = $urandom_range(0, 1);
    load_check_addr  = 32'h100 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
  endtask

  initial begin
    idle();
    rst = 1;
    mq.delete();
    mrel = 0;
    @(negedge clk);

    // Reset values, with a load check presented against the empty queue.
    load_check_valid = 1;
    load_check_addr  = 32'h100;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset sq_empty", sq_empty, 1);
    chk("reset no_rel_pending", no_released_stores_pending, 1);
    chk("reset push_ready", push_ready, 1);
    chk("reset load_conflict", load_conflict, 0);
    doReset();

    // Fill with four stores while the memory side is ready.
    for (int i = 0; i < 4; i++) begin
      idle();
      out_ready = 1;
      setPush(32'h100 + 32'(i * 4), i + 1);
      tick();
    end
    idle();
    out_ready = 1;
    #1;
    chk("full push_ready", push_ready, 0);
    chk("full out_valid", out_valid, 0);
    chk("full sq_empty", sq_empty, 0);
    chk("full no_rel_pending", no_released_stores_pending, 1);
    tick();

    // Release ids 1 and 2 with memory stalled, then drain them.
    idle(); release_valid = 1; release_id = 3'd1; tick();
    idle(); release_valid = 1; release_id = 3'd2; tick();
    idle();
    #1;
    chk("stall out_valid", out_valid, 1);
    chk("stall out_addr", out_addr, 32'h100);
    tick();
    out_ready = 1;
    tick();
    #1;
    chk("drain2 out_addr", out_addr, 32'h104);
    tick();
    #1;
    chk("drained out_valid", out_valid, 0);

    // Pop of a full queue does not admit a same-cycle push.
    idle(); setPush(32'h110, 5); tick();
    idle(); setPush(32'h114, 6); tick();
    idle(); release_valid = 1; release_id = relId(); tick();
    idle(); out_ready = 1; setPush(32'h118, 7);
    #1;
    chk("fullpop push_ready", push_ready, 0);
    chk("fullpop out_valid", out_valid, 1);
    tick();
    #1;
    chk("after pop push_ready", push_ready, 1);
    tick();
    idle();
    #1;
    chk("refilled push_ready", push_ready, 0);
    tick();

    // Flush keeps the released id 5 and drops the unreleased ones and the push.
    doReset();
    idle(); setPush(32'h300, 5); tick();
    idle(); setPush(32'h304, 6); tick();
    idle(); setPush(32'h308, 7); tick();
    idle(); release_valid = 1; release_id = 3'd5; tick();
    idle(); sq_flush = 1; setPush(32'h30C, 0); tick();
    idle();
    #1;
    chk("flush out_valid", out_valid, 1);
    chk("flush out_addr", out_addr, 32'h300);
    chk("flush push_ready", push_ready, 1);
    out_ready = 1;
    tick();
    #1;
    chk("flush drained sq_empty", sq_empty, 1);
    tick();

    // Word-granular conflict check and its one-cycle visibility delay.
    idle(); setPush(32'h200, 1); tick();
    idle(); load_check_valid = 1; load_check_addr = 32'h203;
    #1; chk("conflict 0x203", load_conflict, 1);
    tick();
    load_check_addr = 32'h204;
    #1; chk("conflict 0x204", load_conflict, 0);
    tick();
    setPush(32'h204, 2);
    #1; chk("same-cycle push conflict", load_conflict, 0);
    tick();
    push_valid = 0;
    #1; chk("next-cycle conflict", load_conflict, 1);
    tick();

    // Random traffic wraps every pointer many times over.
    doReset();
    for (int n = 0; n < 400; n++) begin
      applyStimulus();
      tick();
    end

    // Reset asserted while released stores are draining.
    doReset();
    idle(); setPush(32'h400, 1); tick();
    idle(); setPush(32'h404, 2); tick();
    idle(); release_valid = 1; release_id = 3'd1; tick();
    idle(); release_valid = 1; release_id = 3'd2; tick();
    idle(); out_ready = 1; tick();
    #2;
    rst = 1;
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset sq_empty", sq_empty, 1);
    chk("midreset no_rel_pending", no_released_stores_pending, 1);
    chk("midreset push_ready", push_ready, 1);
    mq.delete();
    mrel = 0;
    @(negedge clk);
    tick();
    rst = 0;
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Holds issued stores between the load/store issue stage and the data-memory interface.
- Each entry waits until its store retires, then drains in order to memory through a valid/ready port.
- Supplies the load/store status flags (sq_empty, no_released_stores_pending) and a word-address conflict check for loads.
- Unreleased entries are discarded on a gc sq_flush.

Parameters:
- SQ_DEPTH, 4, number of entries; power of two, at least 2.
- ID_W, LOG2_MAX_IDS, width of instruction id fields.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- push_valid  in  1  new store offered
- push_ready  out  1  queue can accept a store this cycle
- push_addr  in  32  store byte address
- push_be  in  4  byte enables
- push_fn3  in  3  store size/funct3
- push_data  in  32  store data, already aligned
- push_id  in  ID_W  instruction id
- release_valid  in  1  oldest unreleased store has retired
- release_id  in  ID_W  id of the retired store
- sq_flush  in  1  discard all unreleased entries
- load_check_valid  in  1  load address presented
- load_check_addr  in  32  load byte address
- load_conflict  out  1  load overlaps a queued store word
- out_valid  out  1  released store available to memory
- out_ready  in  1  memory accepts the store
- out_addr  out  32  head entry address
- out_be  out  4  head entry byte enables
- out_fn3  out  3  head entry funct3
- out_data  out  32  head entry data
- sq_empty  out  1  no entries held
- no_released_stores_pending  out  1  no released entries awaiting drain

Behaviour:
- Pointers: head (oldest entry), rel (oldest unreleased entry), tail (next free slot).
  - Each pointer is log2(SQ_DEPTH)+1 bits; the MSB is a wrap bit.
  - Invariant: head <= rel <= tail in modular order.
  - count = tail - head; the subtraction wraps mod 2*SQ_DEPTH.
- Reset (async, rst=1): all pointers are 0 and all entry storage is don't-care.
  - Outputs during and after reset: out_valid=0, sq_empty=1, no_released_stores_pending=1, push_ready=1, load_conflict=0.
  - Reset asserted mid-operation drops all contents, including released entries.
- push_ready = (count != SQ_DEPTH), computed from registered state only.
  - A pop in the same cycle does not free a slot for a same-cycle push.
- Push: when push_valid && push_ready && !sq_flush, the entry is written at tail and tail increments.
  - A push with push_ready=0 is ignored; the upstream stage holds the store.
- Release: when release_valid && rel != tail (at cycle start), rel increments.
  - release_id must equal the id stored at rel; a mismatch is a protocol error, flagged by an assertion, and rel still advances.
  - A release when no unreleased entry exists is ignored.
  - A release cannot target an entry pushed in the same cycle.
- Drain: out_valid = (head != rel). out_* present the head entry combinationally from storage.
  - On out_valid && out_ready, head increments.
  - out_* must stay stable while out_valid && !out_ready.
- Flush: on sq_flush, tail <= rel, using rel after any same-cycle release.
  - A same-cycle push is dropped.
  - Released entries are kept and continue draining; a same-cycle pop still occurs.
- Simultaneous push, release and pop in one cycle are all legal; each pointer updates independently.
- Status flags (combinational from registered pointers):
  - sq_empty = (head == tail)
  - no_released_stores_pending = (head == rel)
- Conflict check: load_conflict = load_check_valid && (some entry in [head, tail) has addr[31:2] == load_check_addr[31:2]).
  - Covers both released and unreleased entries.
  - A pushed entry is visible to the check from the next cycle onward.
  - The check has zero-cycle latency; no forwarding is performed.
- Wrap: pointer index bits wrap at SQ_DEPTH and the wrap bit toggles.
  - Full: index bits equal and wrap bits differ. Empty: pointers fully equal.

Test Plan:
- Reset, then push 4 stores (ids 1-4, addrs 0x100, 0x104, 0x108, 0x10C) with out_ready=1 -> push_ready=0 after the 4th, out_valid stays 0, sq_empty=0, no_released_stores_pending=1.
- Release ids 1 and 2 on consecutive cycles with out_ready=0 -> out_valid=1 with out_addr=0x100; raise out_ready -> 0x100 then 0x104 drain, after which out_valid=0.
- Queue full, with head released and out_ready=1, plus push_valid in the same cycle -> pop occurs, push is refused that cycle, and is accepted on the next cycle.
- Entries ids 5-7 with id 5 released; assert sq_flush together with push_valid -> tail=rel, id 5 still drains, the push is dropped, and sq_empty=1 after the drain.
- Entry at 0x200 queued; check 0x203 -> load_conflict=1; check 0x204 -> load_conflict=0; push 0x204 and check it in the same cycle -> 0, next cycle -> 1.
- Run 3×SQ_DEPTH push/release/drain cycles to wrap all pointers, then assert rst mid-drain -> out_valid drops immediately, and sq_empty=1 with no_released_stores_pending=1.
